// File: rtl/spi_host.sv
`default_nettype none
// ============================================================================
//  Module      : spi_host
//  Description : Memory-mapped SPI master (mode 0, MSB-first, 8-bit frames)
//                on the CPU valid/ready bus. Registers: CTRL, STATUS, TX,
//                RX, DIV and CS, addressed by offset bits [4:2].
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_host #(
    parameter int DIV_WIDTH = 16,
    parameter int DIV_RESET = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_valid,
    input  logic        spi_instr,
    input  logic [31:0] spi_addr,
    input  logic [31:0] spi_wdata,
    input  logic [3:0]  spi_wstrb,
    output logic [31:0] spi_rdata,
    output logic        spi_ready,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] c_REG_CTRL   = 3'd0;
    localparam logic [2:0] c_REG_STATUS = 3'd1;
    localparam logic [2:0] c_REG_TX     = 3'd2;
    localparam logic [2:0] c_REG_RX     = 3'd3;
    localparam logic [2:0] c_REG_DIV    = 3'd4;
    localparam logic [2:0] c_REG_CS     = 3'd5;
    localparam logic [DIV_WIDTH-1:0] c_CNT_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    state_t               r_state;
    logic                 r_enable;
    logic                 r_busy;
    logic                 r_rx_valid;
    logic                 r_overrun;
    logic                 r_cs_assert;
    logic [7:0]           r_rxdata;
    logic [7:0]           r_shift;
    logic [3:0]           r_bitcnt;
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_div_q;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 r_sck;
    logic                 r_mosi;
    logic                 r_ready;
    logic [31:0]          r_rdata;

    logic [2:0]  w_sel;
    logic        w_wr;
    logic        w_rd;
    logic        w_tx_wr;
    logic        w_tx_start;
    logic        w_rx_rd;
    logic [31:0] w_bytemask;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Request decode; only offset bits [4:2] select a register
    assign w_sel      = spi_addr[4:2];
    assign w_wr       = spi_valid && (spi_wstrb != 4'b0000);
    assign w_rd       = spi_valid && (spi_wstrb == 4'b0000);
    assign w_tx_wr    = w_wr && (w_sel == c_REG_TX) && spi_wstrb[0];
    assign w_tx_start = w_tx_wr && r_enable && !r_busy;
    assign w_rx_rd    = w_rd && (w_sel == c_REG_RX);
    assign w_bytemask = {{8{spi_wstrb[3]}}, {8{spi_wstrb[2]}},
                         {8{spi_wstrb[1]}}, {8{spi_wstrb[0]}}};
    assign w_unused   = ^{spi_instr, spi_addr[31:5], spi_addr[1:0], spi_wdata};

    // Read-data mux of the current register contents
    always_comb begin
        w_rdata = 32'h0;
        case (w_sel)
            c_REG_CTRL:   w_rdata[0] = r_enable;
            c_REG_STATUS: w_rdata[2:0] = {r_overrun, r_rx_valid, r_busy};
            c_REG_RX:     w_rdata[7:0] = r_rxdata;
            c_REG_DIV:    w_rdata[DIV_WIDTH-1:0] = r_div;
            c_REG_CS:     w_rdata[0] = r_cs_assert;
            default:      w_rdata = 32'h0;
        endcase
    end

    // Bus response: one ready pulse the cycle after each request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            r_ready <= spi_valid;
            r_rdata <= w_rd ? w_rdata : 32'h0;
        end
    end

    // Software-owned registers: CTRL, CS, DIV and the sticky overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable    <= 1'b0;
            r_cs_assert <= 1'b0;
            r_div       <= DIV_WIDTH'(DIV_RESET);
            r_overrun   <= 1'b0;
        end else begin
            if (w_wr && (w_sel == c_REG_CTRL) && spi_wstrb[0])
                r_enable <= spi_wdata[0];
            if (w_wr && (w_sel == c_REG_CS) && spi_wstrb[0])
                r_cs_assert <= spi_wdata[0];
            if (w_wr && (w_sel == c_REG_DIV) && !r_busy)
                r_div <= (r_div & ~w_bytemask[DIV_WIDTH-1:0]) |
                         (spi_wdata[DIV_WIDTH-1:0] & w_bytemask[DIV_WIDTH-1:0]);
            if (w_wr && (w_sel == c_REG_STATUS) && spi_wstrb[0] && spi_wdata[2])
                r_overrun <= 1'b0;
            // A new overrun takes priority over a clear in the same cycle
            if (w_tx_wr && r_enable && r_busy)
                r_overrun <= 1'b1;
        end
    end

    // Transfer FSM: sck half-periods of div_q+1 cycles, sample on rising sck
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rxdata   <= 8'h00;
            r_shift    <= 8'h00;
            r_bitcnt   <= 4'd0;
            r_div_q    <= '0;
            r_cnt      <= '0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
        end else begin
            if (w_rx_rd)
                r_rx_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_tx_start) begin
                        r_shift  <= spi_wdata[7:0];
                        r_mosi   <= spi_wdata[7];
                        r_div_q  <= r_div;
                        r_cnt    <= '0;
                        r_bitcnt <= 4'd0;
                        r_busy   <= 1'b1;
                        r_state  <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (r_cnt == r_div_q) begin
                        r_sck    <= 1'b1;
                        r_shift  <= {r_shift[6:0], spi_miso};
                        r_bitcnt <= r_bitcnt + 4'd1;
                        r_cnt    <= '0;
                        r_state  <= S_HIGH;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (r_cnt == r_div_q) begin
                        r_sck <= 1'b0;
                        r_cnt <= '0;
                        if (r_bitcnt == 4'd8) begin
                            r_state <= S_DONE;
                        end else begin
                            // Sampled bit already shifted in; MSB is next to send
                            r_mosi  <= r_shift[7];
                            r_state <= S_LOW;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_DONE: begin
                    r_rxdata   <= r_shift;
                    r_rx_valid <= 1'b1;
                    r_busy     <= 1'b0;
                    r_mosi     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign spi_ready = r_ready;
    assign spi_rdata = r_rdata;
    assign spi_sck   = r_sck;
    assign spi_mosi  = r_mosi;
    assign spi_cs_n  = ~r_cs_assert;

endmodule
`default_nettype wire

// File: tb/tb_spi_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_host
//  Description : Self-checking bench for spi_host: register table, loopback
//                transfers, MOSI timing, overrun and completion corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_host;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_valid;
    logic        spi_instr;
    logic [31:0] spi_addr;
    logic [31:0] spi_wdata;
    logic [3:0]  spi_wstrb;
    logic [31:0] spi_rdata;
    logic        spi_ready;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_cs_n;

    logic lb;
    logic miso_val;
    assign spi_miso = lb ? spi_mosi : miso_val;

    spi_host #(.DIV_WIDTH(16), .DIV_RESET(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi_valid (spi_valid),
        .spi_instr (spi_instr),
        .spi_addr  (spi_addr),
        .spi_wdata (spi_wdata),
        .spi_wstrb (spi_wstrb),
        .spi_rdata (spi_rdata),
        .spi_ready (spi_ready),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .spi_cs_n  (spi_cs_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] sb_exp[$];
    bit          sb_chk[$];
    string       sb_name[$];

    bit   mon_en    = 1'b0;
    logic exp_ready = 1'b0;

    bit   chk_sck   = 1'b0;
    logic sck_prev  = 1'b0;
    int   rises     = 0;
    int   last_rise = 0;
    int   exp_gap   = 2;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
        bit          chk;
    } vec_t;
    vec_t tbl[24];

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", n, act, exp, $time);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // One bus request per call; the expected response is queued at drive time
    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] e, input bit c, input string n);
        sb_exp.push_back(e);
        sb_chk.push_back(c);
        sb_name.push_back(n);
        spi_valid = 1'b1;
        spi_addr  = a;
        spi_wdata = d;
        spi_wstrb = s;
        spi_instr = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        spi_valid = 1'b0;
        spi_addr  = 32'h0;
        spi_wdata = 32'h0;
        spi_wstrb = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
        bus(a, 32'h0, 4'h0, e, 1'b1, n);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus(a, d, s, 32'h0, 1'b0, "wr");
    endtask

    // Loopback transfer at DIV=0: busy for 16*(0+1)+1 cycles, then RX == TX
    task automatic xfer_div0(input logic [7:0] b, input string tag);
        int nbusy;
        nbusy = 16 * (0 + 1) + 1;
        wr(32'h08, {24'h0, b}, 4'h1);
        for (int i = 0; i < nbusy; i++) rd(32'h04, 32'h1, {tag, "_busy"});
        rd(32'h04, 32'h2, {tag, "_rxv"});
        rd(32'h0C, {24'h0, b}, {tag, "_rxdata"});
        rd(32'h04, 32'h0, {tag, "_rxv_clr"});
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        exp_ready <= rst ? 1'b0 : spi_valid;
    end

    // Response monitor: ready timing and scoreboard pop
    always @(negedge clk) begin
        if (mon_en) begin
            if (spi_ready || exp_ready)
                check("ready", {31'h0, spi_ready}, {31'h0, exp_ready});
            if (spi_ready) begin
                if (sb_exp.size() == 0) begin
                    check("sb_empty", 32'h1, 32'h0);
                end else begin
                    logic [31:0] e;
                    bit          c;
                    string       n;
                    e = sb_exp.pop_front();
                    c = sb_chk.pop_front();
                    n = sb_name.pop_front();
                    if (c) check(n, spi_rdata, e);
                end
            end else begin
                check("rdata_idle", spi_rdata, 32'h0);
            end
        end
    end

    // SCK rising-edge counter and period check while enabled
    always @(negedge clk) begin
        if (chk_sck && spi_sck && !sck_prev) begin
            rises++;
            if (rises > 1) check("sck_period", cyc - last_rise, exp_gap);
            last_rise = cyc;
        end
        sck_prev = spi_sck;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] txb;

        tbl[0]  = '{32'h04, 32'h0,        4'h0, 32'h0,    1'b1};
        tbl[1]  = '{32'h10, 32'h0,        4'h0, 32'h3,    1'b1};
        tbl[2]  = '{32'h00, 32'h0,        4'h0, 32'h0,    1'b1};
        tbl[3]  = '{32'h14, 32'h0,        4'h0, 32'h0,    1'b1};
        tbl[4]  = '{32'h0C, 32'h0,        4'h0, 32'h0,    1'b1};
        tbl[5]  = '{32'h10, 32'hAAAA1234, 4'h1, 32'h0,    1'b0};
        tbl[6]  = '{32'h10, 32'h0,        4'h0, 32'h34,   1'b1};
        tbl[7]  = '{32'h10, 32'h00005678, 4'h2, 32'h0,    1'b0};
        tbl[8]  = '{32'h10, 32'h0,        4'h0, 32'h5634, 1'b1};
        tbl[9]  = '{32'h18, 32'hFFFFFFFF, 4'hF, 32'h0,    1'b0};
        tbl[10] = '{32'h18, 32'h0,        4'h0, 32'h0,    1'b1};
        tbl[11] = '{32'h08, 32'h55,       4'h1, 32'h0,    1'b0};
        tbl[12] = '{32'h04, 32'h0,        4'h0, 32'h0,    1'b1};
        tbl[13] = '{32'h08, 32'h0,        4'h0, 32'h0,    1'b1};
        tbl[14] = '{32'h00, 32'h101,      4'h2, 32'h0,    1'b0};
        tbl[15] = '{32'h00, 32'h0,        4'h0, 32'h0,    1'b1};
        tbl[16] = '{32'h00, 32'h1,        4'h1, 32'h0,    1'b0};
        tbl[17] = '{32'h14, 32'h1,        4'h1, 32'h0,    1'b0};
        tbl[18] = '{32'h10, 32'h0,        4'h3, 32'h0,    1'b0};
        tbl[19] = '{32'h10, 32'h0,        4'h0, 32'h0,    1'b1};
        tbl[20] = '{32'h14, 32'h0,        4'h0, 32'h1,    1'b1};
        tbl[21] = '{32'h00, 32'h0,        4'h0, 32'h1,    1'b1};
        tbl[22] = '{32'h18, 32'h0,        4'h0, 32'h0,    1'b1};
        tbl[23] = '{32'h1C, 32'h0,        4'h0, 32'h0,    1'b1};

        rst = 1'b1; spi_valid = 1'b0; spi_instr = 1'b0; spi_addr = 32'h0;
        spi_wdata = 32'h0; spi_wstrb = 4'h0; lb = 1'b0; miso_val = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // Reset state of the serial pins
        @(negedge clk);
        check("rst_cs_n", {31'h0, spi_cs_n}, 32'h1);
        check("rst_sck",  {31'h0, spi_sck},  32'h0);
        check("rst_mosi", {31'h0, spi_mosi}, 32'h0);
        sync();

        // Register table, applied on consecutive cycles
        for (int i = 0; i < 24; i++)
            bus(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].exp, tbl[i].chk,
                $sformatf("tbl%0d", i));
        @(negedge clk);
        check("cs_n_asserted", {31'h0, spi_cs_n}, 32'h0);
        sync();

        // Loopback at DIV=0 with SCK edge counting
        lb = 1'b1; exp_gap = 2 * (0 + 1); rises = 0; chk_sck = 1'b1;
        xfer_div0(8'hA5, "lb_a5");
        chk_sck = 1'b0;
        check("sck_rises", rises, 8);

        // MISO held high, DIV=2: MOSI bit timing for 0x3C
        lb = 1'b0; miso_val = 1'b1; txb = 8'h3C;
        wr(32'h10, 32'h2, 4'h3);
        wr(32'h08, {24'h0, txb}, 4'h1);
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("mosi_lo_b%0d", k), {31'h0, spi_mosi}, {31'h0, txb[7-k]});
            check($sformatf("sck_lo_b%0d", k),  {31'h0, spi_sck},  32'h0);
            repeat (3) @(posedge clk);
            @(negedge clk);
            check($sformatf("mosi_hi_b%0d", k), {31'h0, spi_mosi}, {31'h0, txb[7-k]});
            check($sformatf("sck_hi_b%0d", k),  {31'h0, spi_sck},  32'h1);
            repeat (3) @(posedge clk);
        end
        #1;
        rd(32'h04, 32'h2, "d2_rxv");
        rd(32'h0C, 32'hFF, "d2_rxdata");
        rd(32'h04, 32'h0, "d2_rxv_clr");

        // Overrun during a DIV=2 transfer; original byte still completes
        lb = 1'b1;
        wr(32'h08, 32'h81, 4'h1);
        rd(32'h04, 32'h1, "ovr_busy");
        wr(32'h08, 32'h11, 4'h1);
        rd(32'h04, 32'h5, "ovr_set");
        repeat (50) @(posedge clk);
        #1;
        rd(32'h04, 32'h6, "ovr_done");
        rd(32'h0C, 32'h81, "ovr_rxdata");
        wr(32'h04, 32'h4, 4'h1);
        rd(32'h04, 32'h0, "ovr_clr");

        // RX read in the DONE cycle: old byte returned, rx_valid still set
        wr(32'h10, 32'h0, 4'h3);
        wr(32'h08, 32'hC3, 4'h1);
        for (int i = 0; i < 16; i++) rd(32'h04, 32'h1, "rdd_busy");
        rd(32'h0C, 32'h81, "rdd_old");
        rd(32'h04, 32'h2, "rdd_rxv");
        rd(32'h0C, 32'hC3, "rdd_new");
        rd(32'h04, 32'h0, "rdd_clr");

        // TX write in the DONE cycle is rejected, accepted the next cycle
        wr(32'h08, 32'h5A, 4'h1);
        for (int i = 0; i < 16; i++) rd(32'h04, 32'h1, "txd_busy");
        wr(32'h08, 32'h33, 4'h1);
        wr(32'h08, 32'h33, 4'h1);
        rd(32'h04, 32'h7, "txd_status");
        repeat (20) @(posedge clk);
        #1;
        rd(32'h0C, 32'h33, "txd_rxdata");
        rd(32'h04, 32'h4, "txd_ovr");
        wr(32'h04, 32'h4, 4'h1);
        rd(32'h04, 32'h0, "txd_clr");

        // Reset in the middle of bit 4 of a DIV=0 transfer
        wr(32'h08, 32'hF0, 4'h1);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_sck",  {31'h0, spi_sck},  32'h0);
        check("mid_rst_cs_n", {31'h0, spi_cs_n}, 32'h1);
        check("mid_rst_mosi", {31'h0, spi_mosi}, 32'h0);
        sync();
        rd(32'h04, 32'h0, "mid_rst_status");
        rd(32'h0C, 32'h0, "mid_rst_rx");
        rd(32'h10, 32'h3, "mid_rst_div");
        rd(32'h00, 32'h0, "mid_rst_ctrl");
        wr(32'h00, 32'h1, 4'h1);
        wr(32'h14, 32'h1, 4'h1);
        wr(32'h10, 32'h0, 4'h3);
        xfer_div0(8'h96, "post_rst");

        // Drain any outstanding responses, bounded
        for (int i = 0; i < 20 && sb_exp.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("sb_drain", sb_exp.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
